symbol_mux_pipe: RTL

//  Parametrised successor to the lane symbol multiplexer. Selects one of NSYM WIDTH-bit symbols per accepted

---
 rtl/symbol_mux_pkg.sv | 24 ++
 rtl/sym_fifo.sv | 57 +++++
 rtl/symbol_mux_pipe.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/symbol_mux_pkg.sv
// Shared constants and types for the lane symbol multiplexer: symbol indices, default K-char mask, SKP FSM states.
// Pure declarations; no latency or backpressure of its own.
package symbol_mux_pkg;

  localparam int TLP_IDX = 0;
  localparam int COM_IDX = 1;
  localparam int PAD_IDX = 2;
  localparam int SKP_IDX = 3;
  localparam int STP_IDX = 4;
  localparam int SDP_IDX = 5;
  localparam int END_IDX = 6;
  localparam int EDB_IDX = 7;
  localparam int FTS_IDX = 8;
  localparam int IDL_IDX = 9;

  localparam logic [9:0] K_MASK_DEFAULT = 10'h3FE;

  typedef enum logic [1:0] {IDLE, PEND, COM, SKP} skp_state_t;

  function automatic logic sel_valid(input int sel, input int nsym);
    return (sel < nsym);
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Synchronous FIFO, sync active-high reset; push lands in the next cycle, pushes while full are ignored.
// Head shows the oldest entry; when empty it holds the last popped word (zero after reset).
module sym_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_pop;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_pop <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        last_pop <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  assign head = empty ? last_pop : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/symbol_mux_pipe.sv
// Selects one of NSYM symbols per accepted request, tags K-char, queues in a DEPTH FIFO (latency 1); ctrlRDY drops when full.
// Optional periodic SKP ordered-set insertion under SYMBOL_MUX_SKP_INSERT_EN; invalid selects only bump errCNT.
module symbol_mux_pipe
  import symbol_mux_pkg::*;
#(
  parameter int              WIDTH        = 8,
  parameter int              NSYM         = 10,
  parameter int              SELW         = 4,
  parameter int              DEPTH        = 4,
  parameter logic [NSYM-1:0] K_MASK       = NSYM'(K_MASK_DEFAULT),
  parameter int              SKP_INTERVAL = 1180,
  parameter int              SKP_COUNT    = 3
) (
  input  logic                  muxCLK,
  input  logic                  muxRST,
  input  logic [NSYM*WIDTH-1:0] symIN,
  input  logic [SELW-1:0]       muxCTRL,
  input  logic                  ctrlVLD,
  output logic                  ctrlRDY,
  output logic [WIDTH-1:0]      muxOUT,
  output logic                  muxK,
  output logic                  muxVLD,
  input  logic                  muxRDY,
  output logic [7:0]            errCNT,
  output logic                  skpACT
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (NSYM > (2 ** SELW)) begin : g_bad_selw
    $error("NSYM exceeds select range");
  end
  if ((SKP_COUNT < 1) || (SKP_COUNT > 4) || (SKP_INTERVAL < 2)) begin : g_bad_skp
    $error("SKP parameters out of range");
  end

  logic             full;
  logic             empty;
  logic [WIDTH:0]   fifo_head;
  logic             push_vld;
  logic [WIDTH:0]   push_dat;
  logic             accept;
  logic             sel_ok;
  logic [WIDTH-1:0] sel_sym;
  logic             sel_k;

  assign sel_ok = sel_valid(int'(muxCTRL), NSYM);
  assign accept = ctrlVLD && ctrlRDY;

  always_comb begin
    sel_sym = '0;
    sel_k   = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      if (int'(muxCTRL) == i) begin
        sel_sym = symIN[i*WIDTH +: WIDTH];
        sel_k   = K_MASK[i];
      end
    end
  end

  always_ff @(posedge muxCLK) begin
    if (muxRST) begin
      errCNT <= '0;
    end else if (accept && !sel_ok && (errCNT != 8'hFF)) begin
      errCNT <= errCNT + 8'd1;
    end
  end

`ifdef SYMBOL_MUX_SKP_INSERT_EN
  localparam int CW = $clog2(SKP_INTERVAL);

  skp_state_t       state;
  skp_state_t       state_nx;
  logic [CW-1:0]    skp_cyc;
  logic [2:0]       skp_num;
  logic             skp_push;
  logic [WIDTH-1:0] skp_sym;

  always_ff @(posedge muxCLK) begin
    if (muxRST) begin
      state   <= IDLE;
      skp_cyc <= '0;
      skp_num <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        skp_cyc <= (skp_cyc == CW'(SKP_INTERVAL - 1)) ? '0 : skp_cyc + 1'b1;
      end else begin
        skp_cyc <= '0;
      end
      if (state != SKP) begin
        skp_num <= '0;
      end else if (!full) begin
        skp_num <= skp_num + 3'd1;
      end
    end
  end

  // PEND waits for room, COM emits the comma, SKP emits SKP_COUNT fillers.
  always_comb begin
    state_nx = state;
    skp_push = 1'b0;
    skp_sym  = '0;
    case (state)
      IDLE: if (skp_cyc == CW'(SKP_INTERVAL - 1)) state_nx = PEND;
      PEND: if (!full) state_nx = COM;
      COM: begin
        skp_sym = symIN[COM_IDX*WIDTH +: WIDTH];
        if (!full) begin
          skp_push = 1'b1;
          state_nx = SKP;
        end
      end
      SKP: begin
        skp_sym = symIN[SKP_IDX*WIDTH +: WIDTH];
        if (!full) begin
          skp_push = 1'b1;
          if (skp_num == 3'(SKP_COUNT - 1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ctrlRDY  = !muxRST && !full && (state == IDLE);
  assign skpACT   = !muxRST && (state != IDLE);
  assign push_vld = skp_push || (accept && sel_ok);
  assign push_dat = skp_push ? {1'b1, skp_sym} : {sel_k, sel_sym};
`else
  assign ctrlRDY  = !muxRST && !full;
  assign skpACT   = 1'b0;
  assign push_vld = accept && sel_ok;
  assign push_dat = {sel_k, sel_sym};
`endif

  sym_fifo #(
    .WIDTH(WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (muxCLK),
    .rst      (muxRST),
    .push     (push_vld),
    .push_data(push_dat),
    .pop      (muxRDY && !muxRST),
    .head     (fifo_head),
    .full     (full),
    .empty    (empty)
  );

  assign muxVLD = !muxRST && !empty;
  assign muxOUT = muxRST ? '0 : fifo_head[WIDTH-1:0];
  assign muxK   = muxRST ? 1'b0 : fifo_head[WIDTH];

endmodule
